// File: rtl/uart_tx_slave_if.sv
// Bus port bundle for the memory-mapped UART transmitter.
// Signals:
//   req_i   request valid (driven by master)
//   we_i    1 = write, 0 = read
//   addr_i  byte address
//   data_i  write data
//   data_o  registered read data (driven by slave)
// Modports: master (core side), slave (uart_tx_slave).
interface uart_tx_slave_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output req_i,
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  req_i,
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/uart_tx_slave.sv
// Memory-mapped UART transmitter: 16-byte register window at BASE_ADDR,
// 4-entry byte FIFO, 8N1 LSB-first serializer on tx_o.
// Registers: 0x0 CTRL (bit0 tx_en), 0x4 STATUS (bit0 busy, bit1 full,
// bit2 overflow W1C), 0x8 BAUD (bits 15:0, min 2), 0xC TXDATA (WO).
// Ports:
//   clk     core clock
//   rst     synchronous active-high reset
//   bus     uart_tx_slave_if.slave (req_i, we_i, addr_i, data_i, data_o)
//   tx_o    serial line, idle high
//   busy_o  copy of STATUS bit0
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned BAUD_DIV  = 434
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_slave_if.slave  bus,
  output logic            tx_o,
  output logic            busy_o
);

  localparam logic [15:0] BaudRst = 16'(BAUD_DIV);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e      r_state;
  logic        r_ctrl_en;
  logic        r_ovf;
  logic [15:0] r_baud;
  logic [7:0]  r_mem [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;
  logic [31:0] r_data_o;
  logic        r_tx;
  logic [7:0]  r_shift;
  logic [2:0]  r_idx;
  logic [15:0] r_period;
  logic [15:0] r_cnt;
  logic        r_parity;

  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_reg;
  logic        w_full;
  logic        w_busy;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_hit      = bus.req_i && (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_wr       = w_hit && bus.we_i;
  assign w_rd       = w_hit && !bus.we_i;
  assign w_reg      = bus.addr_i[3:2];
  assign w_full     = (r_count == 3'd4);
  assign w_busy     = (r_state != StIdle) || (r_count != 3'd0);
  assign w_pop      = (r_state == StIdle) && r_ctrl_en && (r_count != 3'd0);
  assign w_push_req = w_wr && (w_reg == 2'd3);
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_unused_bits = ^{bus.data_i[31:16], bus.addr_i[1:0]};

  always_comb begin
    w_rdata = '0;
    unique case (w_reg)
      2'd0:    w_rdata = {31'd0, r_ctrl_en};
      2'd1:    w_rdata = {29'd0, r_ovf, w_full, w_busy};
      2'd2:    w_rdata = {16'd0, r_baud};
      default: w_rdata = '0;
    endcase
  end

  // Register file, FIFO pointers and read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl_en <= 1'b0;
      r_ovf     <= 1'b0;
      r_baud    <= BaudRst;
      r_wptr    <= 2'd0;
      r_rptr    <= 2'd0;
      r_count   <= 3'd0;
      r_data_o  <= '0;
    end else begin
      if (w_wr) begin
        unique case (w_reg)
          2'd0: r_ctrl_en <= bus.data_i[0];
          2'd1: if (bus.data_i[2]) r_ovf <= 1'b0;
          2'd2: r_baud <= (bus.data_i[15:0] < 16'd2) ? 16'd2 : bus.data_i[15:0];
          default: ;
        endcase
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: ;
      endcase
      r_data_o <= w_rd ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.data_i[7:0];
  end

  // Serializer. r_cnt counts down the latched period; each state transition
  // reloads it, so every bit lasts exactly r_period cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_tx     <= 1'b1;
      r_shift  <= 8'd0;
      r_idx    <= 3'd0;
      r_period <= BaudRst;
      r_cnt    <= 16'd0;
      r_parity <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_parity <= ^r_mem[r_rptr];
            r_period <= r_baud;
            r_cnt    <= r_baud - 16'd1;
            r_tx     <= 1'b0;
            r_state  <= StStart;
          end
        end
        StStart: begin
          if (r_cnt == 16'd0) begin
            r_cnt   <= r_period - 16'd1;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= 3'd0;
            r_state <= StData;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StData: begin
          if (r_cnt == 16'd0) begin
            r_cnt <= r_period - 16'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= StParity;
`else
              r_tx    <= 1'b1;
              r_state <= StStop;
`endif
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (r_cnt == 16'd0) begin
            r_cnt   <= r_period - 16'd1;
            r_tx    <= 1'b1;
            r_state <= StStop;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        StStop: begin
          if (r_cnt == 16'd0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.data_o = r_data_o;
  assign tx_o       = r_tx;
  assign busy_o     = w_busy;

endmodule

// File: tb/tb_uart_tx_slave.sv
module tb_uart_tx_slave;

  localparam logic [31:0] Base   = 32'h3000_0000;
  localparam logic [31:0] ACtrl  = Base + 32'h0;
  localparam logic [31:0] AStat  = Base + 32'h4;
  localparam logic [31:0] ABaud  = Base + 32'h8;
  localparam logic [31:0] AData  = Base + 32'hC;
`ifdef UART_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_slave_if bus_if ();

  uart_tx_slave dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .tx_o   (tx),
    .busy_o (busy)
  );

  // Expected line level for bit slot idx of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = 1'b1;
    bus_if.addr_i = a;
    bus_if.data_i = d;
    @(negedge clk);
    bus_if.req_i  = 1'b0;
    bus_if.we_i   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = 1'b0;
    bus_if.addr_i = a;
    @(posedge clk);
    #1;
    d = bus_if.data_o;
    bus_if.req_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [31:0] exp_rd [5];
    logic [31:0] addrs [5];
    addrs  = '{AStat, ABaud, AData, ACtrl, 32'h4000_0008};
    exp_rd = '{32'd0, 32'd434, 32'd0, 32'd0, 32'd0};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus_if.data_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx=%b busy=%b data_o=%0h, expected 1 0 0",
               tx, busy, bus_if.data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_read(addrs[i], d);
      n_checks++;
      if (d !== exp_rd[i] || tx !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_read[%0h]: got %0h tx=%b, expected %0h tx=1",
                 addrs[i], d, tx, exp_rd[i]);
      end
    end
  endtask

  task automatic test_single_frame;
    logic e;
    bus_write(ABaud, 32'd4);
    bus_write(ACtrl, 32'd1);
    bus_write(AData, 32'hA5);
    @(posedge clk);
    for (int j = 0; j < FrameBits * 4; j++) begin
      #1;
      e = exp_bit(8'hA5, j / 4);
      n_checks++;
      if (tx !== e || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_a5 cycle %0d: got tx=%b busy=%b, expected tx=%b busy=1",
                 j, tx, busy, e);
      end
      @(posedge clk);
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_a5_idle: got busy=%b tx=%b, expected 0 1", busy, tx);
    end
  endtask

  task automatic test_overflow_back_to_back;
    logic [7:0]  bytes [5];
    logic [31:0] d;
    logic        e;
    int          slot;
    int          f;
    int          k;
    logic        saw_low;
    bytes = '{8'h55, 8'h0F, 8'hC3, 8'h81, 8'hEE};
    slot  = FrameBits * 4 + 1;
    bus_write(ACtrl, 32'd0);
    for (int i = 0; i < 5; i++) bus_write(AData, {24'd0, bytes[i]});
    bus_read(AStat, d);
    n_checks++;
    if (d !== 32'h7) begin
      n_fail++;
      $display("FAIL status_full_ovf: got %0h, expected 7", d);
    end
    bus_write(AStat, 32'd4);
    bus_read(AStat, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++;
      $display("FAIL status_ovf_clear: got %0h, expected 3", d);
    end
    bus_write(ACtrl, 32'd1);
    @(posedge clk);
    for (int j = 0; j < 4 * slot; j++) begin
      #1;
      f = j / slot;
      k = j % slot;
      e = (k < FrameBits * 4) ? exp_bit(bytes[f], k / 4) : 1'b1;
      n_checks++;
      if (tx !== e) begin
        n_fail++;
        $display("FAIL b2b frame %0d cycle %0d: got tx=%b, expected %b", f, k, tx, e);
      end
      @(posedge clk);
    end
    saw_low = 1'b0;
    for (int j = 0; j < 50; j++) begin
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
      @(posedge clk);
    end
    n_checks++;
    if (saw_low !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_byte_sent: got activity=%b, expected 0", saw_low);
    end
  endtask

  task automatic test_baud;
    logic [31:0] d;
    logic        e;
    int          f1;
    bus_write(ACtrl, 32'd0);
    bus_write(ABaud, 32'd0);
    bus_read(ABaud, d);
    n_checks++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL baud_zero_clamp: got %0d, expected 2", d);
    end
    bus_write(ABaud, 32'd1);
    bus_read(ABaud, d);
    n_checks++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL baud_one_clamp: got %0d, expected 2", d);
    end
    bus_write(ABaud, 32'd4);
    bus_write(AData, 32'h3C);
    bus_write(AData, 32'hC3);
    bus_write(ACtrl, 32'd1);
    f1 = FrameBits * 4 + 1;
    fork
      begin
        @(posedge clk);
        for (int j = 0; j < f1 + FrameBits * 6; j++) begin
          #1;
          if (j < FrameBits * 4) e = exp_bit(8'h3C, j / 4);
          else if (j == FrameBits * 4) e = 1'b1;
          else e = exp_bit(8'hC3, (j - f1) / 6);
          n_checks++;
          if (tx !== e) begin
            n_fail++;
            $display("FAIL baud_change cycle %0d: got tx=%b, expected %b", j, tx, e);
          end
          @(posedge clk);
        end
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL baud_change_idle: got busy=%b, expected 0", busy);
        end
      end
      begin
        repeat (10) @(negedge clk);
        bus_write(ABaud, 32'd6);
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    logic        e;
    logic        saw_act;
    bus_write(ACtrl, 32'd0);
    bus_write(ABaud, 32'd4);
    bus_write(AData, 32'hF0);
    bus_write(AData, 32'h0F);
    bus_write(ACtrl, 32'd1);
    @(posedge clk);
    for (int j = 0; j < 18; j++) begin
      #1;
      e = exp_bit(8'hF0, j / 4);
      n_checks++;
      if (tx !== e) begin
        n_fail++;
        $display("FAIL pre_reset cycle %0d: got tx=%b, expected %b", j, tx, e);
      end
      @(posedge clk);
    end
    // Edge ahead samples rst while data bit 3 (a 0 for 0xF0) is on the line.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got tx=%b busy=%b, expected 1 0", tx, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_read(AStat, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL status_after_reset: got %0h, expected 0", d);
    end
    bus_write(ACtrl, 32'd1);
    saw_act = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) saw_act = 1'b1;
    end
    n_checks++;
    if (saw_act !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_flushed: got activity=%b, expected 0", saw_act);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic e;
    bus_write(ABaud, 32'd4);
    bus_write(ACtrl, 32'd1);
    bus_write(AData, 32'h07);
    @(posedge clk);
    for (int j = 0; j < 44; j++) begin
      #1;
      e = (j >= 36 && j < 40) ? 1'b1 : exp_bit(8'h07, j / 4);
      n_checks++;
      if (tx !== e) begin
        n_fail++;
        $display("FAIL parity cycle %0d: got tx=%b, expected %b", j, tx, e);
      end
      @(posedge clk);
    end
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_frame_len: got busy=%b, expected 0", busy);
    end
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus_if.req_i  = 1'b0;
    bus_if.we_i   = 1'b0;
    bus_if.addr_i = '0;
    bus_if.data_i = '0;
    test_reset();
    test_single_frame();
    test_overflow_back_to_back();
    test_baud();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
